// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and defaults for the register-file write arbiter
package reg_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ARB_CNT_W  = 16;

    // FSM state doubles as the owner of the current grant cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick from effective requests and last-grant pointer
module rr_pick2 (
    input  logic e0,
    input  logic e1,
    input  logic lp,
    output logic idx,
    output logic valid
);

    // On a tie the requester that did not win last time is chosen
    always_comb begin
        valid = e0 | e1;
        idx   = (e0 & e1) ? ~lp : e1;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the register-file write port (ARB_STATS_EN adds grant counters)
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DROP_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
`ifdef ARB_STATS_EN
    output logic [ARB_CNT_W-1:0] gnt_cnt0,
    output logic [ARB_CNT_W-1:0] gnt_cnt1,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    arb_state_t        state;
    logic              lp;
    logic              e0;
    logic              e1;
    logic              pick_idx;
    logic              pick_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_drop;

    // A requester is masked during its own grant cycle so a held request is not granted twice
    always_comb begin
        e0       = req0 & (state != ST_G0);
        e1       = req1 & (state != ST_G1);
        sel_addr = pick_idx ? addr1 : addr0;
        sel_data = pick_idx ? data1 : data0;
        sel_drop = (DROP_ZERO != 0) && (sel_addr == '0);
    end

    rr_pick2 u_pick (
        .e0    (e0),
        .e1    (e1),
        .lp    (lp),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Grant FSM with registered grant pulses and write-port outputs; address/data hold while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lp      <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pick_valid) begin
            state   <= pick_idx ? ST_G1 : ST_G0;
            lp      <= pick_idx;
            gnt0    <= ~pick_idx;
            gnt1    <= pick_idx;
            wr_en   <= ~sel_drop;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            state   <= ST_IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            wr_en   <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating per-requester grant counters, advanced at the edge that raises the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (pick_valid) begin
            if (!pick_idx && (gnt_cnt0 != '1)) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (pick_idx && (gnt_cnt1 != '1)) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0;
    logic [4:0]  addr0;
    logic [31:0] data0;
    logic        req1;
    logic [4:0]  addr1;
    logic [31:0] data1;

    logic        gnt0, gnt1, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        nd_gnt0, nd_gnt1, nd_wr_en;
    logic [4:0]  nd_wr_addr;
    logic [31:0] nd_wr_data;
`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, nd_cnt0, nd_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_ZERO(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
`ifdef ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    reg_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_ZERO(0)) dut_nd (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(nd_gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(nd_gnt1),
`ifdef ARB_STATS_EN
        .gnt_cnt0(nd_cnt0), .gnt_cnt1(nd_cnt1),
`endif
        .wr_en(nd_wr_en), .wr_addr(nd_wr_addr), .wr_data(nd_wr_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic g0, input logic g1, input logic we,
                              input logic [4:0] a, input logic [31:0] d);
        check({tag, ".gnt0"},    64'(gnt0),    64'(g0));
        check({tag, ".gnt1"},    64'(gnt1),    64'(g1));
        check({tag, ".wr_en"},   64'(wr_en),   64'(we));
        check({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
        check({tag, ".wr_data"}, 64'(wr_data), 64'(d));
    endtask

    initial begin
        // Reset held two cycles while both request
        reset = 1'b1;
        req0 = 1'b1; addr0 = 5'd5; data0 = 32'hAAAA_0000;
        req1 = 1'b1; addr1 = 5'd7; data1 = 32'hBBBB_0000;
        tick();
        expect_out("rst1", 0, 0, 0, 5'd0, 32'd0);
        tick();
        expect_out("rst2", 0, 0, 0, 5'd0, 32'd0);

        // Single requester: grant every second cycle, outputs hold while idle
        reset = 1'b0;
        req1 = 1'b0;
        data0 = 32'hDEAD_BEEF;
        tick();
        expect_out("single_g1", 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
        tick();
        expect_out("single_i1", 0, 0, 0, 5'd5, 32'hDEAD_BEEF);
        tick();
        expect_out("single_g2", 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
        tick();
        expect_out("single_i2", 0, 0, 0, 5'd5, 32'hDEAD_BEEF);
        req0 = 1'b0;
        tick();
        expect_out("single_drop", 0, 0, 0, 5'd5, 32'hDEAD_BEEF);

        // Both requesting after reset: 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; addr0 = 5'd3; data0 = 32'h1111_1111;
        req1 = 1'b1; addr1 = 5'd4; data1 = 32'h2222_2222;
        tick();
        expect_out("alt0", 1, 0, 1, 5'd3, 32'h1111_1111);
        tick();
        expect_out("alt1", 0, 1, 1, 5'd4, 32'h2222_2222);
        data0 = 32'h5555_5555;
        tick();
        expect_out("alt2", 1, 0, 1, 5'd3, 32'h5555_5555);
        tick();
        expect_out("alt3", 0, 1, 1, 5'd4, 32'h2222_2222);

        // Write to register 0: dropped with DROP_ZERO=1, performed with DROP_ZERO=0
        req0 = 1'b0;
        addr1 = 5'd0; data1 = 32'h0000_1234;
        tick();
        expect_out("z_idle", 0, 0, 0, 5'd4, 32'h2222_2222);
        tick();
        expect_out("z_drop", 0, 1, 0, 5'd0, 32'h0000_1234);
        check("z_nd.gnt1",  64'(nd_gnt1),  64'd1);
        check("z_nd.wr_en", 64'(nd_wr_en), 64'd1);
        check("z_nd.wr_data", 64'(nd_wr_data), 64'h1234);

        // Reset during gnt1 cycle clears everything; requester 0 wins afterwards
        reset = 1'b1;
        req0 = 1'b1; addr0 = 5'd2; data0 = 32'h0000_0044;
        req1 = 1'b1; addr1 = 5'd9; data1 = 32'h0000_0033;
        tick();
        expect_out("midrst", 0, 0, 0, 5'd0, 32'd0);
        check("midrst_nd.wr_en", 64'(nd_wr_en), 64'd0);
`ifdef ARB_STATS_EN
        check("cnt0_rst", 64'(gnt_cnt0), 64'd0);
        check("cnt1_rst", 64'(gnt_cnt1), 64'd0);
`endif
        reset = 1'b0;
        tick();
        expect_out("post_rst0", 1, 0, 1, 5'd2, 32'h0000_0044);
        tick();
        expect_out("post_rst1", 0, 1, 1, 5'd9, 32'h0000_0033);
        tick();
        expect_out("post_rst2", 1, 0, 1, 5'd2, 32'h0000_0044);
        tick();
        expect_out("post_rst3", 0, 1, 1, 5'd9, 32'h0000_0033);
        tick();
        expect_out("post_rst4", 1, 0, 1, 5'd2, 32'h0000_0044);

`ifdef ARB_STATS_EN
        check("cnt0_3", 64'(gnt_cnt0), 64'd3);
        check("cnt1_2", 64'(gnt_cnt1), 64'd2);
        force dut.gnt_cnt0 = 16'hFFFF;
        #1;
        release dut.gnt_cnt0;
        tick();
        tick();
        check("cnt0_sat_grant", 64'(gnt0), 64'd1);
        check("cnt0_sat", 64'(gnt_cnt0), 64'hFFFF);
        check("cnt1_3", 64'(gnt_cnt1), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
